// File: rtl/hud_pkg.sv
// Shared encodings for the HUD joystick path: raw GPIO codes, event directions
// and the press-tracking FSM states.
package hud_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [3:0] JOY_IDLE  = 4'h0;
  localparam logic [3:0] JOY_UP    = 4'h1;
  localparam logic [3:0] JOY_DOWN  = 4'h2;
  localparam logic [3:0] JOY_LEFT  = 4'h3;
  localparam logic [3:0] JOY_RIGHT = 4'h4;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } joy_state_t;

  // Any code outside 1..4 is treated as the stick being at rest.
  function automatic logic [3:0] joy_clean(input logic [3:0] code);
    case (code)
      JOY_UP, JOY_DOWN, JOY_LEFT, JOY_RIGHT: return code;
      default:                               return JOY_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] joy_to_dir(input logic [3:0] code);
    case (code)
      JOY_DOWN:  return DIR_DOWN;
      JOY_LEFT:  return DIR_LEFT;
      JOY_RIGHT: return DIR_RIGHT;
      default:   return DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a candidate/counter debouncer; a new value
// is accepted only after DEBOUNCE_CYCLES consecutive identical samples.
module input_debouncer #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [W-1:0]     candidate;
  logic [W-1:0]     candidate_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    candidate_next = candidate;
    cnt_next       = cnt;
    if (sync2 != candidate) begin
      candidate_next = sync2;
      cnt_next       = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // Looking at the next count lets DEBOUNCE_CYCLES=1 accept on the load cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      candidate <= candidate_next;
      cnt       <= cnt_next;
      if (cnt_next == CNT_MAX) begin
        stable <= candidate_next;
      end
    end
  end

endmodule

// File: rtl/joystick_event_encoder.sv
// Turns the debounced joystick code into one-shot direction events with
// auto-repeat, delivered through a single-entry valid/ready output register.
module joystick_event_encoder
  import hud_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000,
  parameter int CNT_W           = 24
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] ext_io,
  output logic       event_valid,
  output logic [1:0] event_dir,
  input  logic       event_ready,
  output logic [3:0] dir_level,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] RPT_MAX = CNT_W'(REPEAT_CYCLES - 1);

  logic [3:0]       raw_clean;
  logic [3:0]       joy_code;
  logic             press;
  logic [1:0]       cur_dir;
  joy_state_t       state;
  logic [1:0]       held_dir;
  logic [CNT_W-1:0] rpt_cnt;
  logic             gen;
  logic             load;

  // Cleaning before the synchroniser is equivalent to cleaning after it,
  // since the mapping is a pure per-sample function.
  assign raw_clean = joy_clean(ext_io);

  input_debouncer #(
    .W              (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debouncer (
    .clock (CLOCK_50),
    .reset (reset),
    .raw   (raw_clean),
    .stable(joy_code)
  );

  assign press     = (joy_code != JOY_IDLE);
  assign cur_dir   = joy_to_dir(joy_code);
  assign dir_level = press ? (4'b0001 << cur_dir) : 4'b0000;

  always_comb begin
    gen = 1'b0;
    case (state)
      IDLE: gen = press;
      HELD: gen = press && ((cur_dir != held_dir) || (rpt_cnt == RPT_MAX));
    endcase
  end

  // Handshake: an event is transferred on any edge where event_valid && event_ready.
  // event_valid/event_dir are held until then; a transfer and a new event on the
  // same edge reload the register instead of emptying it. event_ready only
  // feeds register inputs, never an output directly.
  assign load = gen && (!event_valid || event_ready);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      held_dir    <= DIR_UP;
      rpt_cnt     <= '0;
      event_valid <= 1'b0;
      event_dir   <= DIR_UP;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state    <= HELD;
            held_dir <= cur_dir;
            rpt_cnt  <= '0;
          end
        end
        HELD: begin
          if (!press) begin
            state <= IDLE;
          end else if (gen) begin
            held_dir <= cur_dir;
            rpt_cnt  <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + CNT_W'(1);
          end
        end
      endcase

      if (load) begin
        event_valid <= 1'b1;
        event_dir   <= cur_dir;
      end else if (event_ready) begin
        event_valid <= 1'b0;
      end

      if (gen && !load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_joystick_event_encoder.sv
// Bench for joystick_event_encoder: window-based reference model compared every
// cycle, plus directed scenarios with hand-computed event timings.
module tb_joystick_event_encoder;

  localparam int D = 4;
  localparam int R = 10;

  logic       clk;
  logic       reset;
  logic [3:0] ext_io;
  logic       event_valid;
  logic [1:0] event_dir;
  logic       event_ready;
  logic [3:0] dir_level;
  logic       overrun;

  joystick_event_encoder #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R),
    .CNT_W          (24)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .ext_io     (ext_io),
    .event_valid(event_valid),
    .event_dir  (event_dir),
    .event_ready(event_ready),
    .dir_level  (dir_level),
    .overrun    (overrun)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit model_on = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounced value = the synchronised sample once the last D samples agree.
  int   hist [0:D+1];
  int   m_deb, m_held, m_age;
  int   m_valid, m_dir, m_ovr;
  bit   m_gen, m_stable;

  function automatic int clean(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd4) ? int'(c) : 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    model_on = 1;
    if (reset) begin
      for (int i = 0; i <= D + 1; i++) hist[i] = 0;
      m_deb = 0; m_held = 0; m_age = 0;
      m_valid = 0; m_dir = 0; m_ovr = 0;
    end else begin
      m_gen = 0;
      if (m_deb != 0) begin
        if (m_deb != m_held)      begin m_gen = 1; m_age = 0; end
        else if (m_age == R - 1)  begin m_gen = 1; m_age = 0; end
        else                      m_age++;
      end
      m_held = m_deb;
      if (m_gen) begin
        if (!m_valid || event_ready) begin m_valid = 1; m_dir = m_deb - 1; end
        else m_ovr = 1;
      end else if (event_ready) begin
        m_valid = 0;
      end
      for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = clean(ext_io);
      m_stable = 1;
      for (int i = 3; i <= D + 1; i++) if (hist[i] != hist[2]) m_stable = 0;
      if (m_stable) m_deb = hist[2];
    end
  end

  // ---------------- scoreboard / compare ----------------
  int ev_t_q[$];
  int ev_d_q[$];
  int exp_off[$];
  int exp_dir[$];

  always @(negedge clk) begin
    if (model_on) begin
      check("event_valid", int'(event_valid), m_valid);
      check("event_dir",   int'(event_dir),   m_dir);
      check("overrun",     int'(overrun),     m_ovr);
      check("dir_level",   int'(dir_level),   (m_deb == 0) ? 0 : (1 << (m_deb - 1)));
      if (event_valid && event_ready) begin
        ev_t_q.push_back(cyc);
        ev_d_q.push_back(int'(event_dir));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_events();
    ev_t_q.delete();
    ev_d_q.delete();
  endtask

  task automatic expect_events(input string name, input int t0);
    check({name, "_count"}, ev_t_q.size(), exp_off.size());
    for (int i = 0; i < exp_off.size() && i < ev_t_q.size(); i++) begin
      check({name, "_time"}, ev_t_q[i] - t0, exp_off[i]);
      check({name, "_dir"},  ev_d_q[i],      exp_dir[i]);
    end
  endtask

  // ---------------- directed stimulus ----------------
  int t0;
  bit saw_level;

  initial begin
    reset       = 1'b1;
    ext_io      = 4'h0;
    event_ready = 1'b1;
    tick(2);

    // Reset held with the stick down; press seen 7 cycles after release.
    ext_io = 4'h2;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_valid",   int'(event_valid), 0);
      check("rst_dir",     int'(event_dir),   0);
      check("rst_level",   int'(dir_level),   0);
      check("rst_overrun", int'(overrun),     0);
    end
    reset = 1'b0;
    tick(6);
    check("rst_press_early", int'(event_valid), 0);
    tick(1);
    check("rst_press_valid", int'(event_valid), 1);
    check("rst_press_dir",   int'(event_dir),   1);
    tick(1);
    check("rst_press_width", int'(event_valid), 0);
    ext_io = 4'h0;
    tick(20);

    // Glitch rejection: 3-cycle pulse is ignored, 4-cycle pulse is one press.
    clear_events();
    ext_io = 4'h1;
    tick(3);
    ext_io = 4'h0;
    saw_level = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (dir_level != 4'h0) saw_level = 1;
    end
    check("glitch_level",  int'(saw_level), 0);
    check("glitch_events", ev_t_q.size(),   0);
    clear_events();
    t0 = cyc;
    ext_io = 4'h1;
    tick(4);
    ext_io = 4'h0;
    tick(12);
    exp_off = '{7};
    exp_dir = '{0};
    expect_events("pulse4", t0);

    // Auto-repeat while held right, nothing on release.
    clear_events();
    t0 = cyc;
    ext_io = 4'h4;
    tick(20);
    check("held_level", int'(dir_level), 8);
    tick(20);
    ext_io = 4'h0;
    tick(15);
    exp_off = '{7, 17, 27, 37};
    exp_dir = '{3, 3, 3, 3};
    expect_events("repeat", t0);

    // Codes outside 1..4 are idle.
    clear_events();
    ext_io = 4'h9;
    saw_level = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (dir_level != 4'h0) saw_level = 1;
    end
    ext_io = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (dir_level != 4'h0) saw_level = 1;
    end
    check("invalid_level",  int'(saw_level), 0);
    check("invalid_events", ev_t_q.size(),   0);

    // Direct left -> up change restarts the repeat spacing.
    clear_events();
    t0 = cyc;
    ext_io = 4'h3;
    tick(15);
    ext_io = 4'h1;
    tick(20);
    ext_io = 4'h0;
    tick(15);
    exp_off = '{7, 17, 22, 32};
    exp_dir = '{2, 2, 0, 0};
    expect_events("dir_change", t0);

    // Backpressure: first event held, first repeat dropped -> overrun.
    event_ready = 1'b0;
    t0 = cyc;
    ext_io = 4'h1;
    tick(16);
    check("bp_valid_pre",   int'(event_valid), 1);
    check("bp_overrun_pre", int'(overrun),     0);
    tick(14);
    check("bp_valid",   int'(event_valid), 1);
    check("bp_dir",     int'(event_dir),   0);
    check("bp_overrun", int'(overrun),     1);
    ext_io = 4'h0;
    tick(10);
    event_ready = 1'b1;
    tick(1);
    check("bp_accept", int'(event_valid), 0);
    tick(5);
    check("bp_overrun_sticky", int'(overrun), 1);

    // Reset clears overrun; accept and reload on the same edge.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst2_overrun", int'(overrun), 0);
    event_ready = 1'b0;
    t0 = cyc;
    ext_io = 4'h2;
    tick(16);
    event_ready = 1'b1;
    tick(1);
    event_ready = 1'b0;
    ext_io = 4'h0;
    check("sim_valid",   int'(event_valid), 1);
    check("sim_dir",     int'(event_dir),   1);
    check("sim_overrun", int'(overrun),     0);
    tick(12);
    check("sim_valid_hold",   int'(event_valid), 1);
    check("sim_overrun_hold", int'(overrun),     0);
    event_ready = 1'b1;
    tick(3);
    check("sim_drain", int'(event_valid), 0);

    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/joystick_event_encoder.md
# joystick_event_encoder

Input-side counterpart of the HUD's joystick LED check. It takes the raw 4-bit joystick code on the GPIO header, then synchronises and debounces it. It converts each debounced press into a one-shot direction event, with auto-repeat while the stick is held. Events are delivered to the game FSM over a valid/ready handshake, and a debounced one-hot level is provided for the LEDR diagnostics.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new code (10 ms at 50 MHz); must be ≥ 1.
- REPEAT_CYCLES, 12500000: hold time between auto-repeat events (250 ms); must be ≥ 1.
- CNT_W, 24: width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES).

Ports (one clock; reset is synchronous and active-high):
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- ext_io  in  4  raw joystick code, asynchronous to CLOCK_50. Codes: 4'h1 up, 4'h2 down, 4'h3 left, 4'h4 right; every other value means idle.
- event_valid  out  1  a direction event is pending.
- event_dir  out  2  event direction: 0 up, 1 down, 2 left, 3 right. Held stable while event_valid is high.
- event_ready  in  1  consumer accepts the event in any cycle where event_valid && event_ready.
- dir_level  out  4  debounced one-hot level: bit0 up, bit1 down, bit2 left, bit3 right; 0 when idle.
- overrun  out  1  sticky flag: an event was dropped because the previous event was still unaccepted.

## Operation
- **Synchroniser:** ext_io passes through two flops (sync1, sync2). Codes other than 1–4 are mapped to idle before debouncing.
- **Debouncer:**
  - Holds a candidate code and a counter.
  - If sync2 differs from the candidate, the candidate is loaded with sync2 and the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced code takes the candidate value (if different) and the counter saturates.
  - Glitches shorter than DEBOUNCE_CYCLES never reach the debounced code.
- **FSM states:** IDLE, HELD.
  - IDLE → HELD when the debounced code becomes a direction. An event is generated and the repeat counter is cleared.
  - HELD, same direction: the repeat counter increments. When it reaches REPEAT_CYCLES-1, an event is generated and the counter is cleared.
  - HELD, different direction (direct change with no idle between): stay in HELD, generate an event immediately, clear the repeat counter.
  - HELD → IDLE when the debounced code becomes idle. No event is generated on release.
- **Output register (single entry):**
  - A generated event loads event_dir and sets event_valid when the register is empty, or when it is being accepted in the same cycle.
  - If the register is full and not being accepted, the new event is dropped and overrun is set.
  - overrun is cleared only by reset.
- **Reset:**
  - All outputs are 0 after reset: event_valid=0, event_dir=0, dir_level=0, overrun=0.
  - State returns to IDLE; candidate, debounced code and both counters are cleared.
  - Reset mid-hold discards the pending event. A stick still held after reset is re-debounced and produces a fresh press event.

## Timing
- Press latency: event_valid rises DEBOUNCE_CYCLES+3 cycles after ext_io settles on a direction. That is 2 synchroniser cycles, plus DEBOUNCE_CYCLES to update the debounced code, plus 1 for the output register.
- dir_level updates on the same edge as the debounced code, i.e. one cycle before event_valid.
- Auto-repeat: consecutive events for the same held direction are generated exactly REPEAT_CYCLES cycles apart. This spacing is unaffected by how long the consumer takes, except that dropped events set overrun.
- Handshake: event_valid is held with event_dir stable until accepted.
  - After acceptance, event_valid falls on the next edge unless a new event is loaded on that same edge.
  - An accept and a new event on the same cycle keep event_valid high with the new direction, and do not set overrun.
- No combinational path from event_ready to any output.

## Structure
- Shared package `hud_pkg`:
  - direction encoding constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT;
  - raw joystick code constants JOY_UP=4'h1 … JOY_RIGHT=4'h4;
  - FSM state typedef (IDLE, HELD).
- One sub-module, `input_debouncer`, containing the synchroniser, candidate register and debounce counter. It is parameterised by width and DEBOUNCE_CYCLES, so it can be reused for the KEY buttons.
- The top level contains the FSM, the repeat counter and the output register.

## Test plan
Parameters for the bench: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10, event_ready tied high unless stated.
- **Reset:** hold reset 3 cycles with ext_io=4'h2 → all outputs 0 during reset. After release, event_valid=1 with event_dir=1 exactly 7 cycles later, lasting 1 cycle.
- **Glitch rejection:** ext_io pulses 4'h1 for 3 cycles, then 0 → dir_level stays 0 and no event. The same pulse held for 4 cycles → one event, event_dir=0.
- **Auto-repeat and release:** hold 4'h4 for 40 cycles, then 0 → events with event_dir=3 at press+7, +17, +27, +37; dir_level=4'b1000 while held; no event on release.
- **Direction change and invalid codes:**
  - Hold 4'h3, then switch directly to 4'h1 → event_dir=2, then event_dir=0 exactly 7 cycles after the switch; the repeat counter restarts.
  - ext_io=4'h9 → treated as idle.
- **Backpressure:** event_ready=0, hold 4'h1 for 30 cycles → event_valid stays 1 with event_dir=0 and overrun=1 after the first repeat. Raising event_ready then accepts the event in one cycle; overrun stays 1 until reset.
- **Simultaneous accept and load:** event_ready pulsed on the exact cycle a repeat event is generated → event_valid stays high, event_dir keeps the direction, overrun=0.
